// File: rtl/pdm_demod_if.sv
// pdm_demod_if: signal bundle between a PDM receiver and its controller.
//   en, sample_en, clr_err : control from the controller side
//   pdm, pdm_n             : differential PDM pin pair (async to clk)
//   duty_out, duty_vld     : recovered 16-bit duty word and its update pulse
//   pol_err                : sticky polarity-violation flag
// modport master: controller / pin driver side; modport slave: the demodulator.
interface pdm_demod_if;
    logic        en;
    logic        sample_en;
    logic        pdm;
    logic        pdm_n;
    logic        clr_err;
    logic [15:0] duty_out;
    logic        duty_vld;
    logic        pol_err;

    modport master (
        output en, sample_en, pdm, pdm_n, clr_err,
        input  duty_out, duty_vld, pol_err
    );

    modport slave (
        input  en, sample_en, pdm, pdm_n, clr_err,
        output duty_out, duty_vld, pol_err
    );
endinterface

// File: rtl/pdm_demod.sv
// pdm_demod: boxcar-decimating demodulator for a differential 1-bit PDM stream.
// Counts ones over 2^DECIM_LOG2 strobed samples and scales the count to a
// 16-bit duty word (a full-ones window saturates to 16'hFFFF).
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pdm_demod_if.slave (en, sample_en, pdm, pdm_n, clr_err in;
//            duty_out, duty_vld, pol_err out)
// Parameters: DECIM_LOG2 (1..16), SYNC_STAGES (>=2).
// Optional build macro PDM_DEMOD_IIR_EN adds a first-order smoother
// (y += (x - y) >>> 2) between the decimator and duty_out.
module pdm_demod #(
    parameter int unsigned DECIM_LOG2  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    pdm_demod_if.slave  bus
);
    localparam int unsigned SHIFT = 16 - DECIM_LOG2;

    logic [SYNC_STAGES-1:0] p_sync_q, p_sync_d;
    logic [SYNC_STAGES-1:0] pn_sync_q, pn_sync_d;
    logic [DECIM_LOG2-1:0]  samp_cnt_q, samp_cnt_d;
    logic [DECIM_LOG2:0]    ones_cnt_q, ones_cnt_d;
    logic [15:0]            duty_out_q, duty_out_d;
    logic                   duty_vld_q, duty_vld_d;
    logic                   pol_err_q, pol_err_d;

    logic                   p_s, pn_s;
    logic                   sample;
    logic                   win_end;
    logic [DECIM_LOG2:0]    total;
    logic [15:0]            x_val;

`ifdef PDM_DEMOD_IIR_EN
    logic                   first_q, first_d;
    logic signed [17:0]     iir_diff;
    logic signed [17:0]     iir_sum;
`endif

    assign p_s  = p_sync_q[SYNC_STAGES-1];
    assign pn_s = pn_sync_q[SYNC_STAGES-1];

    always_comb begin
        p_sync_d  = {p_sync_q[SYNC_STAGES-2:0], bus.pdm};
        pn_sync_d = {pn_sync_q[SYNC_STAGES-2:0], bus.pdm_n};

        sample  = bus.en & bus.sample_en;
        win_end = sample && (samp_cnt_q == '1);

        // The sample taken on the closing edge is folded in here so the
        // counters can restart on that same edge with no dead sample.
        total = ones_cnt_q + (DECIM_LOG2+1)'(p_s);
        if (total[DECIM_LOG2]) x_val = '1;
        else                   x_val = 16'(total[DECIM_LOG2-1:0]) << SHIFT;

        samp_cnt_d = samp_cnt_q;
        ones_cnt_d = ones_cnt_q;
        duty_out_d = duty_out_q;
        duty_vld_d = 1'b0;

        if (!bus.en) begin
            samp_cnt_d = '0;
            ones_cnt_d = '0;
        end else if (bus.sample_en) begin
            if (win_end) begin
                samp_cnt_d = '0;
                ones_cnt_d = '0;
                duty_vld_d = 1'b1;
            end else begin
                samp_cnt_d = samp_cnt_q + DECIM_LOG2'(1);
                ones_cnt_d = total;
            end
        end

`ifdef PDM_DEMOD_IIR_EN
        first_d  = first_q;
        iir_diff = $signed({2'b00, x_val}) - $signed({2'b00, duty_out_q});
        iir_sum  = $signed({2'b00, duty_out_q}) + (iir_diff >>> 2);
        if (!bus.en) first_d = 1'b1;
        if (win_end) begin
            duty_out_d = first_q ? x_val : iir_sum[15:0];
            first_d    = 1'b0;
        end
`else
        if (win_end) duty_out_d = x_val;
`endif

        // Set is applied after clear so a coincident violation wins.
        pol_err_d = pol_err_q;
        if (bus.clr_err)              pol_err_d = 1'b0;
        if (sample && (p_s == pn_s))  pol_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_sync_q   <= '0;
            pn_sync_q  <= '0;
            samp_cnt_q <= '0;
            ones_cnt_q <= '0;
            duty_out_q <= '0;
            duty_vld_q <= 1'b0;
            pol_err_q  <= 1'b0;
        end else begin
            p_sync_q   <= p_sync_d;
            pn_sync_q  <= pn_sync_d;
            samp_cnt_q <= samp_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            duty_out_q <= duty_out_d;
            duty_vld_q <= duty_vld_d;
            pol_err_q  <= pol_err_d;
        end
    end

`ifdef PDM_DEMOD_IIR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) first_q <= 1'b1;
        else        first_q <= first_d;
    end
`endif

    assign bus.duty_out = duty_out_q;
    assign bus.duty_vld = duty_vld_q;
    assign bus.pol_err  = pol_err_q;
endmodule

// File: tb/tb_pdm_demod.sv
module tb_pdm_demod;
    localparam int unsigned DL  = 8;
    localparam int unsigned SS  = 2;
    localparam int unsigned WIN = 1 << DL;

    typedef struct {
        int unsigned cyc;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pdm_demod_if bus ();

    pdm_demod #(.DECIM_LOG2(DL), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    exp_t        sb[$];
    int unsigned cyc = 0;
    logic        ph[$];
    logic        pnh[$];
    int unsigned ones = 0;
    int unsigned nsamp = 0;
    logic [15:0] m_duty = '0;
    logic        m_pol = 1'b0;
    bit          m_first = 1'b1;
    int unsigned n_win_model = 0;

    initial begin
        for (int i = 0; i < int'(SS); i++) begin
            ph.push_back(1'b0);
            pnh.push_back(1'b0);
        end
    end

    always @(posedge clk) begin
        logic ps, pns;
        int unsigned xv;
        int d, y;
        cyc++;
        if (!rst_n) begin
            ph.delete();
            pnh.delete();
            for (int i = 0; i < int'(SS); i++) begin
                ph.push_back(1'b0);
                pnh.push_back(1'b0);
            end
            ones = 0; nsamp = 0; m_duty = '0; m_pol = 1'b0; m_first = 1'b1;
            sb.delete();
        end else begin
            // ph[0] is the newest pin capture; ph[SS-1] is what reaches the counters.
            ps  = ph[SS-1];
            pns = pnh[SS-1];
            ph.push_front(bus.pdm);   void'(ph.pop_back());
            pnh.push_front(bus.pdm_n); void'(pnh.pop_back());

            if (bus.clr_err) m_pol = 1'b0;
            if (bus.en && bus.sample_en && ps == pns) m_pol = 1'b1;

            if (!bus.en) begin
                ones = 0; nsamp = 0; m_first = 1'b1;
            end else if (bus.sample_en) begin
                ones += int'(ps);
                nsamp++;
                if (nsamp == WIN) begin
                    xv = ones * (1 << (16 - DL));
                    if (xv > 65535) xv = 65535;
`ifdef PDM_DEMOD_IIR_EN
                    if (m_first) m_duty = xv[15:0];
                    else begin
                        y = int'(m_duty);
                        d = int'(xv) - y;
                        m_duty = 16'(y + (d >>> 2));
                    end
                    m_first = 1'b0;
`else
                    m_duty = xv[15:0];
`endif
                    sb.push_back('{cyc, m_duty});
                    n_win_model++;
                    ones = 0; nsamp = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_vld_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit due;
        exp_t e;
        #1;
        due = (sb.size() > 0) && (sb[0].cyc == cyc);
        if (bus.duty_vld) n_vld_seen++;
        if (bus.duty_vld || due) begin
            chk("duty_vld", 32'(bus.duty_vld), 32'(due));
            if (due) begin
                e = sb.pop_front();
                chk("duty_out_window", 32'(bus.duty_out), 32'(e.val));
            end
        end
        chk("duty_out_hold", 32'(bus.duty_out), 32'(m_duty));
        chk("pol_err", 32'(bus.pol_err), 32'(m_pol));
    end

    // ---------------- stimulus ----------------
    int unsigned strobe = 0;

    // kind: 0 const 1, 1 const 0, 2 alternate per strobe, 3 1000 per strobe, 4 random
    task automatic run(input int unsigned n, input int unsigned kind, input int unsigned sp);
        logic b;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            bus.sample_en = ((k % sp) == sp - 1);
            case (kind)
                0: b = 1'b1;
                1: b = 1'b0;
                2: b = (strobe % 2) == 0;
                3: b = (strobe % 4) == 0;
                default: b = 1'($urandom_range(0, 1));
            endcase
            bus.pdm   = b;
            bus.pdm_n = ~b;
            if (bus.sample_en) strobe++;
        end
    endtask

    initial begin
        bus.en = 1'b1; bus.sample_en = 1'b0; bus.pdm = 1'b0; bus.pdm_n = 1'b1; bus.clr_err = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(3 * WIN, 0, 1);
        run(2 * WIN, 1, 1);
        run(2 * WIN + 10, 2, 1);
        run(2 * WIN + 10, 3, 1);
        run(4 * WIN + 20, 2, 4);

        // polarity violation, clear, then clear coincident with violation
        @(negedge clk); bus.sample_en = 1'b1; bus.pdm = 1'b1; bus.pdm_n = 1'b1;
        run(10, 4, 1);
        @(negedge clk); bus.clr_err = 1'b1;
        @(negedge clk); bus.clr_err = 1'b0;
        run(10, 4, 1);
        @(negedge clk); bus.pdm = 1'b0; bus.pdm_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk); bus.clr_err = 1'b0;
        run(20, 4, 1);
        @(negedge clk); bus.clr_err = 1'b1;
        @(negedge clk); bus.clr_err = 1'b0;

        // en dropped mid-window, then a fresh window
        @(negedge clk); bus.en = 1'b0;
        @(negedge clk); bus.en = 1'b1;
        run(100, 4, 1);
        @(negedge clk); bus.en = 1'b0;
        run(20, 4, 1);
        @(negedge clk); bus.en = 1'b1;
        run(WIN + 10, 0, 1);
        run(WIN, 4, 1);

        // reset mid-window
        run(150, 4, 1);
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(2 * WIN, 4, 1);

        // randomized traffic with occasional violations and clears
        for (int unsigned k = 0; k < 3000; k++) begin
            @(negedge clk);
            bus.sample_en = ($urandom_range(0, 99) < 70);
            bus.pdm       = 1'($urandom_range(0, 1));
            bus.pdm_n     = ($urandom_range(0, 99) < 2) ? bus.pdm : ~bus.pdm;
            bus.clr_err   = ($urandom_range(0, 99) < 2);
        end
        @(negedge clk); bus.clr_err = 1'b0; bus.sample_en = 1'b0;
        repeat (4) @(negedge clk);

        chk("windows_seen", n_vld_seen, n_win_model);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pdm_demod.md
Name: pdm_demod

Overview:
Receive-side counterpart of the team's 16-bit sigma-delta PDM modulator. It takes a differential 1-bit PDM stream (pdm/pdm_n) and recovers a 16-bit duty/PCM word. The recovery uses boxcar decimation: it counts ones over a window of 2^DECIM_LOG2 samples, then scales the count to 16 bits. It sits at an external PDM input pin pair, feeding control or measurement logic at clk rate.

Parameters:
DECIM_LOG2, 8, log2 of samples per decimation window; legal range 1..16.
SYNC_STAGES, 2, flops in each input synchronizer; legal minimum 2.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  block enable; low clears window state.
sample_en  input  1  sample strobe; one PDM bit is taken per clk with sample_en=1.
pdm  input  1  PDM stream, true polarity, asynchronous to clk.
pdm_n  input  1  PDM stream, complement polarity, asynchronous to clk.
clr_err  input  1  synchronous clear of pol_err.
duty_out  output  16  recovered duty word, held between windows.
duty_vld  output  1  one-clk pulse when duty_out updates.
pol_err  output  1  sticky flag: pdm/pdm_n polarity violation detected.

Behaviour:
- Reset (async, rst_n=0):
  - sync flops = 0; ones_cnt = 0; samp_cnt = 0.
  - duty_out = 16'h0000; duty_vld = 0; pol_err = 0.
- Synchronizers:
  - pdm and pdm_n each pass through SYNC_STAGES flops, giving p_s and pn_s.
  - Pin-to-p_s latency is SYNC_STAGES clks.
- Sampling (en=1 and sample_en=1):
  - samp_cnt (DECIM_LOG2 bits) increments, wrapping at 2^DECIM_LOG2.
  - ones_cnt (DECIM_LOG2+1 bits) adds p_s.
- Window end: the edge where samp_cnt = 2^DECIM_LOG2-1 and sample_en=1.
  - total = ones_cnt + p_s.
  - duty_out <= total << (16-DECIM_LOG2); if total = 2^DECIM_LOG2, duty_out saturates to 16'hFFFF.
  - duty_vld <= 1 for exactly that one following clk.
  - ones_cnt <= 0 and samp_cnt <= 0 on the same edge, so there is no dead sample between windows.
- sample_en=0: counters hold; duty_vld=0.
- sample_en=1 every clk is legal; windows then complete every 2^DECIM_LOG2 clks.
- en=0:
  - ones_cnt and samp_cnt are cleared synchronously; any partial window is discarded.
  - duty_vld=0; duty_out holds its last value.
  - Synchronizers keep running.
  - The first window after en rises begins at the first strobe.
- Polarity check: on every sampled strobe (en=1, sample_en=1) with p_s == pn_s, pol_err <= 1.
  - pol_err is sticky.
  - clr_err=1 clears it; if a violation coincides with clr_err, set wins.
  - pol_err has no effect on the data path; only p_s is counted.
- Reset mid-window: all state returns to reset values immediately; no duty_vld is produced for the partial window.
- DECIM_LOG2=16: shift amount is 0; a full-ones window saturates to 16'hFFFF.

Optional Feature:
Macro: PDM_DEMOD_IIR_EN.
- Defined:
  - A first-order smoother follows decimation. x is the scaled/saturated window value and y is the register driving duty_out.
  - On each window end, y <= y + ((x - y) >>> 2), computed in 18-bit signed arithmetic and truncated to 16 bits.
  - The first window after reset or after en rises loads y <= x directly.
  - duty_vld timing is unchanged.
- Undefined: duty_out = x; no smoother flops are present.

Test Plan:
All tests use DECIM_LOG2=8, sample_en=1 every clk and en=1 unless noted.
- pdm=1, pdm_n=0 constant -> duty_vld every 256 clks with duty_out=16'hFFFF; pol_err stays 0.
- pdm=0, pdm_n=1 constant -> duty_out=16'h0000 each window.
- pdm alternating 1,0 (pdm_n its complement) -> duty_out=16'h8000; pattern 1,0,0,0 -> 16'h4000.
- sample_en pulsed every 4th clk with the 1,0 pattern -> duty_vld every 1024 clks, duty_out=16'h8000.
- pdm=pdm_n=1 for one strobe -> pol_err=1 and held; clr_err pulse clears it; clr_err coincident with a new violation -> pol_err stays 1.
- en dropped after 100 samples, then raised -> no duty_vld for the partial window; next duty_vld comes 256 strobes after en rises with the correct value. Also assert rst_n mid-window -> duty_out=0, no duty_vld.
